// File: rtl/disp_scanner_pkg.sv
// Shared definitions for the board-side debug display scanner.
package disp_scanner_pkg;

    // Display modes (legacy-compatible constant encoding)
    localparam logic [1:0] MODE_REG   = 2'd0;
    localparam logic [1:0] MODE_MEM   = 2'd1;
    localparam logic [1:0] MODE_PC    = 2'd2;
    localparam logic [1:0] MODE_INSTR = 2'd3;

    localparam logic [6:0] REG_IDX_MAX = 7'd31;
    localparam logic [6:0] MEM_IDX_MAX = 7'd127;

    // Hex digit to active-low segments, bit order gfedcba
    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/disp_scanner_if.sv
// Debug-port and display bundle between the scanner, mips_top and the board pins.
interface disp_scanner_if;
    logic [6:0]  Disp;
    logic [31:0] DispReg;
    logic [31:0] DispMem;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [3:0]  Stat;
    logic [1:0]  Mode;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    // Scanner side
    modport master (
        output Disp, Mode, AN, SEG, DP,
        input  DispReg, DispMem, PC, Instr, Stat
    );

    // CPU debug port / board side
    modport slave (
        input  Disp, Mode, AN, SEG, DP,
        output DispReg, DispMem, PC, Instr, Stat
    );
endinterface

// File: rtl/disp_scanner_btn_debounce.sv
// Raw button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          rise_q;

    // Accept a new level only after it has differed from the current one for DEBOUNCE_CYC cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            rise_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                    rise_q  <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/disp_scanner.sv
// Debug display scanner: selects mips_top debug data, multiplexes 8 hex digits onto 7-seg.
module disp_scanner
    import disp_scanner_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           btn_next_i,
    input  logic           btn_prev_i,
    input  logic           btn_mode_i,
    disp_scanner_if.master dbg
);
    localparam int DW = $clog2(CLK_DIV);

    logic next_p, prev_p, mode_p;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_next_i), .rise_o(next_p));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prev (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_prev_i), .rise_o(prev_p));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_mode_i), .rise_o(mode_p));

    logic [1:0]    mode_q, mode_d;
    logic [6:0]    disp_q, disp_d;
    logic [DW-1:0] div_q;
    logic [2:0]    digit_q;
    logic          first_q;
    logic [31:0]   val_q;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    // Mode FSM and index counter; a mode step takes priority over index steps
    always_comb begin
        mode_d = mode_q;
        disp_d = disp_q;
        if (mode_p) begin
            mode_d = mode_q + 2'd1;
            if (mode_d == MODE_REG)
                disp_d[6:5] = 2'b00;
        end else if (next_p ^ prev_p) begin
            case (mode_q)
                MODE_REG: begin
                    if (next_p)
                        disp_d = (disp_q[4:0] == REG_IDX_MAX[4:0]) ? 7'd0
                                                                   : {2'b00, disp_q[4:0] + 5'd1};
                    else
                        disp_d = (disp_q[4:0] == 5'd0) ? REG_IDX_MAX
                                                       : {2'b00, disp_q[4:0] - 5'd1};
                end
                MODE_MEM: begin
                    if (next_p)
                        disp_d = (disp_q == MEM_IDX_MAX) ? 7'd0 : disp_q + 7'd1;
                    else
                        disp_d = (disp_q == 7'd0) ? MEM_IDX_MAX : disp_q - 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Mode/index state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_REG;
            disp_q <= 7'd0;
        end else begin
            mode_q <= mode_d;
            disp_q <= disp_d;
        end
    end

    logic        tick;
    logic [2:0]  cur_digit;
    logic        load;
    logic [31:0] src;
    logic [31:0] val_d;
    logic [3:0]  nib;

    // Digit selection for the coming slot; Val is captured only at frame start so a frame never tears
    always_comb begin
        tick      = (div_q == DW'(CLK_DIV - 1));
        cur_digit = first_q ? 3'd0 : digit_q + 3'd1;
        load      = tick && (cur_digit == 3'd0);
        case (mode_q)
            MODE_REG:   src = dbg.DispReg;
            MODE_MEM:   src = dbg.DispMem;
            MODE_PC:    src = dbg.PC;
            default:    src = dbg.Instr;
        endcase
        val_d = load ? src : val_q;
        nib   = val_d[{cur_digit, 2'b00} +: 4];
    end

    // Refresh divider, digit counter, Val capture and registered segment drive
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q   <= '0;
            digit_q <= 3'd0;
            first_q <= 1'b1;
            val_q   <= 32'd0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                digit_q <= cur_digit;
                first_q <= 1'b0;
                val_q   <= val_d;
                an_q    <= ~(8'b1 << cur_digit);
                seg_q   <= hex7seg(nib);
                dp_q    <= cur_digit[2] ? 1'b1 : ~dbg.Stat[cur_digit[1:0]];
            end
        end
    end

    assign dbg.Disp = disp_q;
    assign dbg.Mode = mode_q;
    assign dbg.AN   = an_q;
    assign dbg.SEG  = seg_q;
    assign dbg.DP   = dp_q;
endmodule

// File: tb/tb_disp_scanner.sv
// Directed bench for disp_scanner with a behavioural mips_top debug-port model.
module tb_disp_scanner;
    localparam int CLK_DIV      = 4;
    localparam int DEBOUNCE_CYC = 3;
    localparam int B_NEXT = 0, B_PREV = 1, B_MODE = 2, B_BOTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bn = 1'b0, bp = 1'b0, bm = 1'b0;
    int   tests = 0;
    int   fails = 0;

    disp_scanner_if ifc ();

    disp_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
        .clk_i(clk), .rst_i(rst),
        .btn_next_i(bn), .btn_prev_i(bp), .btn_mode_i(bm),
        .dbg(ifc.master)
    );

    always #5 clk = ~clk;

    // mips_top debug port model
    always_comb begin
        ifc.DispReg = {23'd0, ifc.Disp, 2'b01};
        ifc.DispMem = 32'hA000_0000 | {25'd0, ifc.Disp};
    end

    typedef struct {
        int         btn;
        logic [6:0] disp;
        logic [1:0] mode;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input int b);
        bn = (b == B_NEXT) || (b == B_BOTH);
        bp = (b == B_PREV) || (b == B_BOTH);
        bm = (b == B_MODE);
        repeat (12) @(posedge clk);
        bn = 1'b0; bp = 1'b0; bm = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [7:0] v, input string nm);
        int n = 0;
        while (ifc.AN !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {24'd0, ifc.AN}, {24'd0, v});
    endtask

    logic [3:0] pc_nib [8];
    logic [6:0] font   [16];

    initial begin
        font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        pc_nib = '{4'hC, 4'h1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};

        tbl[0]  = '{B_PREV, 7'd0,   2'd0};
        tbl[1]  = '{B_PREV, 7'd31,  2'd0};
        tbl[2]  = '{B_NEXT, 7'd0,   2'd0};
        tbl[3]  = '{B_PREV, 7'd31,  2'd0};
        tbl[4]  = '{B_BOTH, 7'd31,  2'd0};
        tbl[5]  = '{B_NEXT, 7'd0,   2'd0};
        tbl[6]  = '{B_MODE, 7'd0,   2'd1};
        tbl[7]  = '{B_PREV, 7'd127, 2'd1};
        tbl[8]  = '{B_NEXT, 7'd0,   2'd1};
        tbl[9]  = '{B_NEXT, 7'd1,   2'd1};
        tbl[10] = '{B_MODE, 7'd45,  2'd2};
        tbl[11] = '{B_NEXT, 7'd45,  2'd2};
        tbl[12] = '{B_MODE, 7'd45,  2'd3};
        tbl[13] = '{B_PREV, 7'd45,  2'd3};
        tbl[14] = '{B_MODE, 7'd13,  2'd0};

        ifc.PC    = 32'h0000_0000;
        ifc.Instr = 32'h1234_5678;
        ifc.Stat  = 4'b0000;

        // Reset for one edge
        @(posedge clk);
        @(negedge clk);
        chk("rst_disp", {25'd0, ifc.Disp}, 32'd0);
        chk("rst_mode", {30'd0, ifc.Mode}, 32'd0);
        chk("rst_an",   {24'd0, ifc.AN},   32'hFF);
        chk("rst_seg",  {25'd0, ifc.SEG},  32'h7F);
        chk("rst_dp",   {31'd0, ifc.DP},   32'd1);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("first_an",  {24'd0, ifc.AN},  32'hFE);
        chk("first_seg", {25'd0, ifc.SEG}, {25'd0, font[1]});
        chk("first_dp",  {31'd0, ifc.DP},  32'd1);

        // Bouncy Next press: 1-0-1 then held
        bn = 1'b1; @(posedge clk);
        bn = 1'b0; @(posedge clk);
        bn = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bounce_disp", {25'd0, ifc.Disp}, 32'd1);
        bn = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("release_disp", {25'd0, ifc.Disp}, 32'd1);

        // Button vector table; reach MEM index 45 before the mode walk
        for (int i = 0; i < 15; i++) begin
            if (i == 10) begin
                for (int k = 0; k < 44; k++) press(B_NEXT);
                chk("mem45", {25'd0, ifc.Disp}, 32'd45);
            end
            press(tbl[i].btn);
            chk($sformatf("vec%0d_disp", i), {25'd0, ifc.Disp}, {25'd0, tbl[i].disp});
            chk($sformatf("vec%0d_mode", i), {30'd0, ifc.Mode}, {30'd0, tbl[i].mode});
        end

        // PC display frame
        ifc.PC   = 32'h0040_001C;
        ifc.Stat = 4'b0101;
        press(B_MODE);
        press(B_MODE);
        chk("pc_mode", {30'd0, ifc.Mode}, 32'd2);
        wait_an(8'h7F, "wait_d7");
        wait_an(8'hFE, "wait_d0");
        for (int d = 0; d < 8; d++) begin
            logic [7:0] an_exp;
            an_exp = ~(8'b1 << d);
            chk($sformatf("pc_an%0d", d),  {24'd0, ifc.AN},  {24'd0, an_exp});
            chk($sformatf("pc_seg%0d", d), {25'd0, ifc.SEG}, {25'd0, font[pc_nib[d]]});
            chk($sformatf("pc_dp%0d", d),  {31'd0, ifc.DP},
                {31'd0, !((d == 0) || (d == 2))});
            repeat (CLK_DIV) @(posedge clk);
            @(negedge clk);
        end

        // Reset mid-frame at digit 5
        wait_an(8'hDF, "wait_d5");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_an",   {24'd0, ifc.AN},   32'hFF);
        chk("mid_rst_seg",  {25'd0, ifc.SEG},  32'h7F);
        chk("mid_rst_dp",   {31'd0, ifc.DP},   32'd1);
        chk("mid_rst_mode", {30'd0, ifc.Mode}, 32'd0);
        chk("mid_rst_disp", {25'd0, ifc.Disp}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("restart_an",  {24'd0, ifc.AN},  32'hFE);
        chk("restart_seg", {25'd0, ifc.SEG}, {25'd0, font[1]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
